// File: rtl/fp16_pkg.sv
// Shared FP16 types, constants and classification helpers for the
// accumulator datapath (truncating, flush-to-zero, canonical NaN 16'h7FFF).
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] FP16_QNAN = 16'h7FFF;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        ACCEPT,
        ALIGN,
        ADD,
        NORM,
        OUTPUT
    } acc_state_t;

    function automatic logic is_nan(input fp16_t v);
        return (v.exp == '1) && (v.frac != '0);
    endfunction

    function automatic logic is_inf(input fp16_t v);
        return (v.exp == '1) && (v.frac == '0);
    endfunction

    // Subnormals count as zero: only the exponent field matters.
    function automatic logic is_zero_ftz(input fp16_t v);
        return (v.exp == '0);
    endfunction

    function automatic logic [13:0] mantissa14(input fp16_t v);
        return is_zero_ftz(v) ? 14'd0 : {1'b1, v.frac, 3'b000};
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Combinational 15-bit leading-zero counter; an all-zero input reports 15.
module fp16_lzc (
    input  logic [14:0] value,
    output logic [3:0]  count
);

    always_comb begin
        count = 4'd15;
        // Scanning upward lets the most significant set bit win.
        for (int i = 0; i < 15; i++) begin
            if (value[i]) begin
                count = 4'(14 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_accumulator.sv
// Streaming FP16 reduction stage: sums a vector of products (one per 4
// cycles) and presents the result, element count and sticky flags on a held handshake.
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_ovf
);

    acc_state_t         state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        x_q, x_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               nan_q, nan_d;
    logic               ovf_q, ovf_d;

    logic               spec_q, spec_d;
    logic [15:0]        spec_val_q, spec_val_d;
    logic               big_sign_q, big_sign_d;
    logic               small_sign_q, small_sign_d;
    logic [13:0]        big_man_q, big_man_d;
    logic [13:0]        small_man_q, small_man_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [14:0]        sum_q, sum_d;
    logic               sum_sign_q, sum_sign_d;

    fp16_t              op_a, op_b, op_big, op_small;
    logic               a_zero, b_zero, a_is_big;
    logic [14:0]        a_mag, b_mag;
    logic [4:0]         exp_diff;
    logic               align_spec;
    logic [15:0]        align_spec_val;
    logic [13:0]        align_small_man;

    logic [3:0]         lzc_count;
    logic [3:0]         norm_shift;
    logic [14:0]        norm_man;
    logic signed [6:0]  norm_exp;
    logic [15:0]        norm_res;
    logic               norm_ovf;
    logic               unused_norm_bits;

    // ALIGN: classify operands, pick the larger magnitude and line up the smaller.
    always_comb begin
        op_a            = fp16_t'(acc_q);
        op_b            = fp16_t'(x_q);
        a_zero          = is_zero_ftz(op_a);
        b_zero          = is_zero_ftz(op_b);
        a_mag           = a_zero ? 15'd0 : {op_a.exp, op_a.frac};
        b_mag           = b_zero ? 15'd0 : {op_b.exp, op_b.frac};
        a_is_big        = (a_mag >= b_mag);
        op_big          = a_is_big ? op_a : op_b;
        op_small        = a_is_big ? op_b : op_a;
        exp_diff        = op_big.exp - (is_zero_ftz(op_small) ? 5'd0 : op_small.exp);
        align_small_man = (exp_diff >= 5'd14) ? 14'd0 : (mantissa14(op_small) >> exp_diff);

        align_spec      = 1'b1;
        align_spec_val  = FP16_QNAN;
        if (is_nan(op_a) || is_nan(op_b)) begin
            align_spec_val = FP16_QNAN;
        end else if (is_inf(op_a) && is_inf(op_b) && (op_a.sign != op_b.sign)) begin
            align_spec_val = FP16_QNAN;
        end else if (is_inf(op_a)) begin
            align_spec_val = acc_q;
        end else if (is_inf(op_b)) begin
            align_spec_val = x_q;
        end else if (a_zero && b_zero) begin
            align_spec_val = {op_a.sign & op_b.sign, 15'd0};
        end else begin
            align_spec     = 1'b0;
        end
    end

    fp16_lzc u_lzc (
        .value (sum_q),
        .count (lzc_count)
    );

    // NORM: the implicit one belongs at bit 13, so a non-carry sum moves left by lzc-1.
    always_comb begin
        norm_shift = lzc_count - 4'd1;
        norm_man   = sum_q;
        norm_exp   = exp_q;
        norm_res   = 16'h0000;
        norm_ovf   = 1'b0;
        if (sum_q[14]) begin
            norm_man = sum_q >> 1;
            norm_exp = exp_q + 7'sd1;
        end else begin
            norm_man = sum_q << norm_shift;
            norm_exp = exp_q - signed'({3'b000, norm_shift});
        end

        if (spec_q) begin
            norm_res = spec_val_q;
        end else if (sum_q == 15'd0) begin
            norm_res = 16'h0000;
        end else if (norm_exp >= 7'sd31) begin
            norm_res = sum_sign_q ? FP16_NINF : FP16_PINF;
            norm_ovf = 1'b1;
        end else if (norm_exp <= 7'sd0) begin
            norm_res = {sum_sign_q, 15'd0};
        end else begin
            norm_res = {sum_sign_q, norm_exp[4:0], norm_man[12:3]};
        end
    end

    assign unused_norm_bits = ^{norm_man[14:13], norm_man[2:0]};

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        x_d          = x_q;
        last_d       = last_q;
        count_d      = count_q;
        nan_d        = nan_q;
        ovf_d        = ovf_q;
        spec_d       = spec_q;
        spec_val_d   = spec_val_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        big_man_d    = big_man_q;
        small_man_d  = small_man_q;
        exp_d        = exp_q;
        sum_d        = sum_q;
        sum_sign_d   = sum_sign_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        unique case (state_q)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = in_data;
                    last_d  = in_last;
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                spec_d       = align_spec;
                spec_val_d   = align_spec_val;
                big_sign_d   = op_big.sign;
                small_sign_d = op_small.sign;
                big_man_d    = mantissa14(op_big);
                small_man_d  = align_small_man;
                exp_d        = signed'({2'b00, op_big.exp});
                state_d      = ADD;
            end
            ADD: begin
                // The larger magnitude sits in big_man, so subtraction never borrows.
                if (big_sign_q != small_sign_q) begin
                    sum_d = {1'b0, big_man_q - small_man_q};
                end else begin
                    sum_d = {1'b0, big_man_q} + {1'b0, small_man_q};
                end
                sum_sign_d = big_sign_q;
                state_d    = NORM;
            end
            NORM: begin
                acc_d   = norm_res;
                nan_d   = nan_q | is_nan(fp16_t'(norm_res));
                ovf_d   = ovf_q | norm_ovf;
                state_d = last_q ? OUTPUT : ACCEPT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = 16'h0000;
                    count_d = '0;
                    nan_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ACCEPT;
                end
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCEPT;
            acc_q        <= 16'h0000;
            x_q          <= 16'h0000;
            last_q       <= 1'b0;
            count_q      <= '0;
            nan_q        <= 1'b0;
            ovf_q        <= 1'b0;
            spec_q       <= 1'b0;
            spec_val_q   <= 16'h0000;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            big_man_q    <= 14'd0;
            small_man_q  <= 14'd0;
            exp_q        <= 7'sd0;
            sum_q        <= 15'd0;
            sum_sign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            last_q       <= last_d;
            count_q      <= count_d;
            nan_q        <= nan_d;
            ovf_q        <= ovf_d;
            spec_q       <= spec_d;
            spec_val_q   <= spec_val_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            big_man_q    <= big_man_d;
            small_man_q  <= small_man_d;
            exp_q        <= exp_d;
            sum_q        <= sum_d;
            sum_sign_q   <= sum_sign_d;
        end
    end

    assign out_data  = acc_q;
    assign out_count = count_q;
    assign out_nan   = nan_q;
    assign out_ovf   = ovf_q;

endmodule
